spad_req_arbiter: RTL and testbench
===================================

SPAD_REQ_ARBITER -- requirements
Module: spad_req_arbiter

Interface
REQ-001 The block SHALL have parameters, one per line: name, default, meaning.
- ADDR_W, 20, scratchpad request address width.
- DATA_W, 128, write-data width.
- MAX_OUT, 4, maximum outstanding requests per source.
- CNT_W, $clog2(MAX_OUT+1), outstanding-counter width (derived).

REQ-002 The block SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- n_rst, in, 1, reset; one clock; reset is synchronous and active-low.
- fe_req_valid, in, 1, frontend request valid.
- fe_req_ready, out, 1, frontend request accepted.
- fe_req_write, in, 1, 1=write, 0=read.
- fe_req_addr, in, ADDR_W, frontend address.
- fe_req_wdata, in, DATA_W, frontend write data.
- be_req_valid, be_req_ready, be_req_write, be_req_addr, be_req_wdata: backend equivalents, same directions and widths.
- out_valid, out, 1, request to scratchpad head valid.
- out_ready, in, 1, scratchpad head accepts.
- out_write, out, 1, forwarded write flag.
- out_src, out, 1, 0=SRC_FE, 1=SRC_BE.
- out_addr, out, ADDR_W, forwarded address.
- out_wdata, out, DATA_W, forwarded write data.
- rsp_valid, in, 1, tail completed one request.
- rsp_src, in, 1, source of the completed request.
- drain_req, in, 1, request quiesce.
- drain_done, out, 1, pipeline empty and no grants.
- fe_outstanding, out, CNT_W, FE in-flight count.
- be_outstanding, out, CNT_W, BE in-flight count.
- rsp_err, out, 1, sticky: response seen with zero count.

Function
REQ-003 Output stage SHALL be a single registered slot; out_* SHALL come directly from the slot registers.
REQ-004 While out_valid=1 and out_ready=0, out_* SHALL hold stable.
REQ-005 The slot is free when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle.
REQ-006 Source X SHALL be eligible when X_req_valid=1 and X_outstanding < MAX_OUT.
REQ-007 A grant SHALL occur only in state RUN with the slot free and at least one source eligible.
REQ-008 On a grant, the slot SHALL load the granted payload with out_src=granted source on the next edge.
REQ-009 X_req_ready SHALL be combinational and equal 1 only in a cycle where X is granted.
REQ-010 Latency from accepted request to out_valid SHALL be 1 cycle.
REQ-011 Back-to-back grants SHALL sustain 1 request per cycle when out_ready=1.
REQ-012 Arbitration SHALL be round-robin on a last-grant pointer: when both sources are eligible, grant the source not granted last. A single eligible source SHALL always win.
REQ-013 The pointer SHALL update only on a grant.
REQ-014 X_outstanding SHALL increment on a grant to X and decrement on rsp_valid with rsp_src=X.
REQ-015 A simultaneous grant and response for the same source SHALL leave the count unchanged.
REQ-016 A response to a source whose count is 0 SHALL leave the count at 0 and set rsp_err=1 until reset.
REQ-017 Counts SHALL never exceed MAX_OUT; REQ-006 guarantees this.
REQ-018 The FSM SHALL have states RUN, DRAIN, DONE.
- RUN to DRAIN on drain_req=1.
- DRAIN to DONE when out_valid=0 and both counts are 0.
- DRAIN to RUN if drain_req=0.
- DONE to RUN when drain_req=0.
REQ-019 No grants SHALL occur in DRAIN or DONE. A slot already loaded SHALL still drain, and responses SHALL still be counted.
REQ-020 drain_done SHALL be 1 only in DONE.
REQ-021 A drain_req asserted with an empty pipeline SHALL produce drain_done 2 cycles later.

Reset
REQ-022 When n_rst=0 at a clk edge, the block SHALL set all of the following, regardless of any in-flight transaction:
- state RUN.
- out_valid, out_write, out_src, out_addr, out_wdata = 0.
- both counts = 0, rsp_err = 0, drain_done = 0.
- last-grant pointer = BE, so FE wins the first tie.
REQ-023 During reset, fe_req_ready and be_req_ready SHALL be 0.

Verification
REQ-024 Tie after reset: both valid every cycle, out_ready=1 -> grants FE, BE, FE, BE; out_src 0,1,0,1 starting 1 cycle after first request.
REQ-025 Credit stall, MAX_OUT=4:
- FE issues 4 requests, no responses -> fe_req_ready=0 on the 5th request.
- one rsp_valid with rsp_src=0 -> 5th request granted the next cycle; fe_outstanding returns to 4.
REQ-026 Backpressure: out_ready=0 for 3 cycles with slot full -> out_* stable, both ready=0; out_ready=1 -> new grant in the same cycle.
REQ-027 Drain: 2 BE requests in flight, drain_req=1 -> no grants; after 2 responses -> drain_done=1; drain_req=0 -> RUN and grants resume.
REQ-028 Simultaneous and erroneous events:
- grant and response to BE in the same cycle -> be_outstanding unchanged.
- rsp_valid with rsp_src=0 while fe_outstanding=0 -> rsp_err=1, count stays 0.
REQ-029 Reset mid-operation: n_rst=0 with slot full and counts 3/2 -> next cycle all outputs 0, state RUN.

Source files
------------

// File: rtl/spad_req_arbiter.sv
// Two-source scratchpad request arbiter. Frontend and backend requests compete for a single
// registered output slot. Round-robin on ties, per-source outstanding credit limit, and a
// drain/quiesce handshake that stops new grants while in-flight work completes.
module spad_req_arbiter #(
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic              clk,
  input  logic              n_rst,

  input  logic              fe_req_valid,
  output logic              fe_req_ready,
  input  logic              fe_req_write,
  input  logic [ADDR_W-1:0] fe_req_addr,
  input  logic [DATA_W-1:0] fe_req_wdata,

  input  logic              be_req_valid,
  output logic              be_req_ready,
  input  logic              be_req_write,
  input  logic [ADDR_W-1:0] be_req_addr,
  input  logic [DATA_W-1:0] be_req_wdata,

  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_write,
  output logic              out_src,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_wdata,

  input  logic              rsp_valid,
  input  logic              rsp_src,

  input  logic              drain_req,
  output logic              drain_done,

  output logic [CNT_W-1:0]  fe_outstanding,
  output logic [CNT_W-1:0]  be_outstanding,
  output logic              rsp_err
);

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_OUT);

  state_e              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic                out_write_q, out_write_d;
  logic                out_src_q, out_src_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [DATA_W-1:0]   out_wdata_q, out_wdata_d;
  logic [CNT_W-1:0]    fe_cnt_q, fe_cnt_d;
  logic [CNT_W-1:0]    be_cnt_q, be_cnt_d;
  logic                rsp_err_q, rsp_err_d;
  // 0: frontend granted last, 1: backend granted last
  logic                last_q, last_d;

  logic fe_elig, be_elig, slot_free, can_grant, fe_gnt, be_gnt;
  logic fe_rsp, be_rsp;

  // A matching grant and response cancel; a response against an empty count is ignored.
  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] cnt,
                                                 input logic inc, input logic dec);
    logic [CNT_W-1:0] res;
    res = cnt;
    if (inc && !dec) begin
      res = cnt + CNT_W'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      res = cnt - CNT_W'(1);
    end
    return res;
  endfunction

  // Eligibility and round-robin grant decision.
  always_comb begin
    fe_elig   = fe_req_valid && (fe_cnt_q < MaxCnt);
    be_elig   = be_req_valid && (be_cnt_q < MaxCnt);
    slot_free = !out_valid_q || out_ready;
    // n_rst gating keeps both readies low while reset is held
    can_grant = n_rst && (state_q == StRun) && slot_free;
    fe_gnt    = can_grant && fe_elig && (!be_elig || last_q);
    be_gnt    = can_grant && be_elig && (!fe_elig || !last_q);
  end

  assign fe_req_ready = fe_gnt;
  assign be_req_ready = be_gnt;

  // Output slot load/hold/release, credit counters, sticky error and pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_write_d = out_write_q;
    out_src_d   = out_src_q;
    out_addr_d  = out_addr_q;
    out_wdata_d = out_wdata_q;
    last_d      = last_q;

    if (fe_gnt) begin
      out_valid_d = 1'b1;
      out_write_d = fe_req_write;
      out_src_d   = 1'b0;
      out_addr_d  = fe_req_addr;
      out_wdata_d = fe_req_wdata;
      last_d      = 1'b0;
    end else if (be_gnt) begin
      out_valid_d = 1'b1;
      out_write_d = be_req_write;
      out_src_d   = 1'b1;
      out_addr_d  = be_req_addr;
      out_wdata_d = be_req_wdata;
      last_d      = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    fe_rsp    = rsp_valid && !rsp_src;
    be_rsp    = rsp_valid && rsp_src;
    fe_cnt_d  = next_cnt(fe_cnt_q, fe_gnt, fe_rsp);
    be_cnt_d  = next_cnt(be_cnt_q, be_gnt, be_rsp);
    rsp_err_d = rsp_err_q || (fe_rsp && (fe_cnt_q == '0)) || (be_rsp && (be_cnt_q == '0));
  end

  // Drain FSM next-state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (drain_req) state_d = StDrain;
      end
      StDrain: begin
        if (!drain_req) begin
          state_d = StRun;
        end else if (!out_valid_q && (fe_cnt_q == '0) && (be_cnt_q == '0)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (!drain_req) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= StRun;
      out_valid_q <= 1'b0;
      out_write_q <= 1'b0;
      out_src_q   <= 1'b0;
      out_addr_q  <= '0;
      out_wdata_q <= '0;
      fe_cnt_q    <= '0;
      be_cnt_q    <= '0;
      rsp_err_q   <= 1'b0;
      last_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_write_q <= out_write_d;
      out_src_q   <= out_src_d;
      out_addr_q  <= out_addr_d;
      out_wdata_q <= out_wdata_d;
      fe_cnt_q    <= fe_cnt_d;
      be_cnt_q    <= be_cnt_d;
      rsp_err_q   <= rsp_err_d;
      last_q      <= last_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_write      = out_write_q;
  assign out_src        = out_src_q;
  assign out_addr       = out_addr_q;
  assign out_wdata      = out_wdata_q;
  assign fe_outstanding = fe_cnt_q;
  assign be_outstanding = be_cnt_q;
  assign rsp_err        = rsp_err_q;
  assign drain_done     = (state_q == StDone);

endmodule

// File: tb/tb_spad_req_arbiter.sv
// Bench for spad_req_arbiter: directed scenarios followed by random traffic, all checked
// cycle by cycle against a behavioural model of the arbiter's rules.
module tb_spad_req_arbiter;

  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 128;
  localparam int MAX_OUT = 4;
  localparam int CNT_W   = $clog2(MAX_OUT + 1);

  logic              clk = 1'b0;
  logic              n_rst;
  logic              fe_req_valid, fe_req_ready, fe_req_write;
  logic [ADDR_W-1:0] fe_req_addr;
  logic [DATA_W-1:0] fe_req_wdata;
  logic              be_req_valid, be_req_ready, be_req_write;
  logic [ADDR_W-1:0] be_req_addr;
  logic [DATA_W-1:0] be_req_wdata;
  logic              out_valid, out_ready, out_write, out_src;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_wdata;
  logic              rsp_valid, rsp_src, drain_req, drain_done, rsp_err;
  logic [CNT_W-1:0]  fe_outstanding, be_outstanding;

  spad_req_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .MAX_OUT(MAX_OUT)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .fe_req_valid  (fe_req_valid),
    .fe_req_ready  (fe_req_ready),
    .fe_req_write  (fe_req_write),
    .fe_req_addr   (fe_req_addr),
    .fe_req_wdata  (fe_req_wdata),
    .be_req_valid  (be_req_valid),
    .be_req_ready  (be_req_ready),
    .be_req_write  (be_req_write),
    .be_req_addr   (be_req_addr),
    .be_req_wdata  (be_req_wdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_write     (out_write),
    .out_src       (out_src),
    .out_addr      (out_addr),
    .out_wdata     (out_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_src       (rsp_src),
    .drain_req     (drain_req),
    .drain_done    (drain_done),
    .fe_outstanding(fe_outstanding),
    .be_outstanding(be_outstanding),
    .rsp_err       (rsp_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model. mode: 0 run, 1 draining, 2 done.
  bit                m_known = 0;
  int                m_mode;
  bit                m_vld, m_wr, m_src;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  int                m_cnt[2];
  bit                m_err;
  int                m_last;

  // -1 no grant, 0 frontend, 1 backend
  function automatic int pick_grant();
    bit el0, el1;
    if (!n_rst || !m_known || m_mode != 0) return -1;
    if (m_vld && !out_ready) return -1;
    el0 = fe_req_valid && (m_cnt[0] < MAX_OUT);
    el1 = be_req_valid && (m_cnt[1] < MAX_OUT);
    if (el0 && el1) return (m_last == 1) ? 0 : 1;
    if (el0) return 0;
    if (el1) return 1;
    return -1;
  endfunction

  task automatic model_update(input int g);
    int nmode;
    bit rsp_for[2];
    if (!n_rst) begin
      m_known = 1; m_mode = 0; m_vld = 0; m_wr = 0; m_src = 0; m_addr = '0; m_data = '0;
      m_cnt[0] = 0; m_cnt[1] = 0; m_err = 0; m_last = 1;
      return;
    end
    nmode = m_mode;
    if (m_mode == 0 && drain_req) nmode = 1;
    else if (m_mode == 1 && !drain_req) nmode = 0;
    else if (m_mode == 1 && !m_vld && m_cnt[0] == 0 && m_cnt[1] == 0) nmode = 2;
    else if (m_mode == 2 && !drain_req) nmode = 0;
    rsp_for[0] = rsp_valid && !rsp_src;
    rsp_for[1] = rsp_valid && rsp_src;
    for (int s = 0; s < 2; s++) begin
      if (rsp_for[s] && m_cnt[s] == 0) m_err = 1;
      if (g == s && !rsp_for[s]) m_cnt[s] += 1;
      else if (g != s && rsp_for[s] && m_cnt[s] > 0) m_cnt[s] -= 1;
    end
    if (g == 0) begin
      m_vld = 1; m_wr = fe_req_write; m_src = 0; m_addr = fe_req_addr; m_data = fe_req_wdata;
    end else if (g == 1) begin
      m_vld = 1; m_wr = be_req_write; m_src = 1; m_addr = be_req_addr; m_data = be_req_wdata;
    end else if (out_ready) begin
      m_vld = 0;
    end
    if (g >= 0) m_last = g;
    m_mode = nmode;
  endtask

  // One clock: fresh payloads, check readies, advance model, check registered outputs.
  task automatic step();
    int g;
    fe_req_write = 1'($urandom);
    be_req_write = 1'($urandom);
    fe_req_addr  = ADDR_W'($urandom);
    be_req_addr  = ADDR_W'($urandom);
    fe_req_wdata = {$urandom, $urandom, $urandom, $urandom};
    be_req_wdata = {$urandom, $urandom, $urandom, $urandom};
    #1;
    g = pick_grant();
    chk("fe_req_ready", fe_req_ready, g == 0);
    chk("be_req_ready", be_req_ready, g == 1);
    model_update(g);
    @(posedge clk);
    #2;
    if (m_known) begin
      chk("out_valid", out_valid, m_vld);
      if (m_vld) begin
        chk("out_write", out_write, m_wr);
        chk("out_src", out_src, m_src);
        chk("out_addr", out_addr, m_addr);
        chk("out_wdata", out_wdata, m_data);
      end
      chk("fe_outstanding", fe_outstanding, m_cnt[0]);
      chk("be_outstanding", be_outstanding, m_cnt[1]);
      chk("rsp_err", rsp_err, m_err);
      chk("drain_done", drain_done, m_mode == 2);
    end
  endtask

  task automatic idle_inputs();
    fe_req_valid = 0; be_req_valid = 0; out_ready = 1;
    rsp_valid = 0; rsp_src = 0; drain_req = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    n_rst = 0;
    step();
    step();
    n_rst = 1;
  endtask

  initial begin
    int exp_src[4];
    exp_src = '{0, 1, 0, 1};
    idle_inputs();
    n_rst = 0;
    #1;
    do_reset();
    chk("reset_out_valid", out_valid, 0);
    chk("reset_drain_done", drain_done, 0);

    // Tie after reset: FE, BE, FE, BE.
    fe_req_valid = 1; be_req_valid = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("tie_src", out_src, exp_src[i]);
    end
    fe_req_valid = 0; be_req_valid = 0;
    rsp_valid = 1;
    for (int i = 0; i < 4; i++) begin
      rsp_src = 1'(i);
      step();
    end
    rsp_valid = 0;

    // Credit stall at MAX_OUT, released by one response.
    do_reset();
    fe_req_valid = 1;
    for (int i = 0; i < 4; i++) step();
    chk("credit_cnt4", fe_outstanding, 4);
    chk("credit_stall", fe_req_ready, 0);
    rsp_valid = 1; rsp_src = 0;
    step();
    rsp_valid = 0;
    chk("credit_release", fe_req_ready, 1);
    step();
    chk("credit_cnt_back", fe_outstanding, 4);
    fe_req_valid = 0;

    // Backpressure: slot holds, no readies, then BE granted in the release cycle.
    do_reset();
    fe_req_valid = 1; be_req_valid = 1; out_ready = 0;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_fe_ready", fe_req_ready, 0);
      chk("bp_src", out_src, 0);
    end
    out_ready = 1;
    #1;
    chk("bp_release_be", be_req_ready, 1);
    step();
    fe_req_valid = 0; be_req_valid = 0;

    // Drain with two BE requests in flight.
    do_reset();
    be_req_valid = 1;
    step();
    step();
    be_req_valid = 0; drain_req = 1;
    step();
    be_req_valid = 1;
    step();
    chk("drain_no_grant", be_req_ready, 0);
    rsp_valid = 1; rsp_src = 1;
    step();
    step();
    rsp_valid = 0;
    step();
    chk("drain_done_set", drain_done, 1);
    drain_req = 0;
    step();
    chk("drain_resume", be_req_ready, 1);
    step();
    be_req_valid = 0;
    rsp_valid = 1; rsp_src = 1;
    step();
    rsp_valid = 0;

    // Drain with empty pipeline: done two cycles after request.
    do_reset();
    drain_req = 1;
    step();
    chk("drain_empty_c1", drain_done, 0);
    step();
    chk("drain_empty_c2", drain_done, 1);
    drain_req = 0;
    step();

    // Simultaneous grant/response on BE, then erroneous FE response.
    do_reset();
    be_req_valid = 1;
    step();
    rsp_valid = 1; rsp_src = 1;
    step();
    chk("sim_be_cnt", be_outstanding, 1);
    be_req_valid = 0; rsp_src = 0;
    step();
    rsp_valid = 0;
    chk("err_set", rsp_err, 1);
    chk("err_cnt0", fe_outstanding, 0);

    // Reset mid-operation with slot full and counts 3/2.
    do_reset();
    fe_req_valid = 1;
    for (int i = 0; i < 3; i++) step();
    fe_req_valid = 0; be_req_valid = 1;
    for (int i = 0; i < 2; i++) step();
    be_req_valid = 0; out_ready = 0;
    chk("mid_fe3", fe_outstanding, 3);
    chk("mid_be2", be_outstanding, 2);
    n_rst = 0;
    step();
    chk("rst_valid", out_valid, 0);
    chk("rst_write", out_write, 0);
    chk("rst_src", out_src, 0);
    chk("rst_addr", out_addr, 0);
    chk("rst_wdata", out_wdata, 0);
    chk("rst_fe_cnt", fe_outstanding, 0);
    chk("rst_be_cnt", be_outstanding, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_done", drain_done, 0);
    n_rst = 1;
    out_ready = 1;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      int rs;
      n_rst        = ($urandom_range(0, 299) != 0);
      fe_req_valid = ($urandom_range(0, 3) != 0);
      be_req_valid = ($urandom_range(0, 3) != 0);
      out_ready    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) drain_req = ~drain_req;
      rs = int'($urandom_range(0, 1));
      rsp_src = 1'(rs);
      if ($urandom_range(0, 99) == 0) rsp_valid = 1;
      else rsp_valid = (m_cnt[rs] > 0) && ($urandom_range(0, 2) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
